// File: rtl/nibble_packer.sv
// Pairs a qualified 4-bit stream into bytes and queues them in a
// first-word-fall-through FIFO with valid/ready output and sticky overflow.
module nibble_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter bit LOW_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [3:0]                    d,
    input  logic                          d_en,
    input  logic                          flush,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LV_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_half;
    logic         w_load_half;
    logic         w_push;
    logic [7:0]   w_byte;

    logic [7:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]  r_level;
    logic         r_overflow;

    logic         w_valid;
    logic         w_full;
    logic         w_pop;
    logic         w_wr;
    logic         w_drop;

    // Pack state and the pending first nibble of a pair
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_EMPTY;
            r_half  <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_half) begin
                r_half <= d;
            end
        end
    end

    // Next pack state and the byte to enqueue this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_load_half = 1'b0;
        w_push      = 1'b0;
        w_byte      = 8'h00;
        unique case (r_state)
            S_EMPTY: begin
                if (d_en && flush) begin
                    w_push = 1'b1;
                    w_byte = LOW_FIRST ? {4'h0, d} : {d, 4'h0};
                end else if (d_en) begin
                    w_load_half = 1'b1;
                    w_state_nxt = S_HALF;
                end
            end
            S_HALF: begin
                if (d_en) begin
                    w_push      = 1'b1;
                    w_byte      = LOW_FIRST ? {d, r_half} : {r_half, d};
                    w_state_nxt = S_EMPTY;
                end else if (flush) begin
                    w_push      = 1'b1;
                    w_byte      = LOW_FIRST ? {4'h0, r_half} : {r_half, 4'h0};
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LV_FULL);
    assign w_pop   = w_valid & out_ready;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Byte storage; stale entries are masked by the level count
    always_ff @(posedge clk) begin
        if (w_wr && !clr) begin
            r_mem[r_wptr] <= w_byte;
        end
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky record of any byte lost to a full FIFO
    always_ff @(posedge clk) begin
        if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_valid = w_valid;
    assign out_data  = w_valid ? r_mem[r_rptr] : 8'h00;
    assign full      = w_full;
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: both nibble orders driven in parallel and
// compared against a queue-based model of the pairing and FIFO rules.
module tb_nibble_packer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] d;
    logic       d_en;
    logic       flush;
    logic       out_ready;

    logic [7:0] lo_data, hi_data;
    logic       lo_valid, hi_valid;
    logic       lo_full, hi_full;
    logic [2:0] lo_level, hi_level;
    logic       lo_ovf, hi_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] qlo[$];
    logic [7:0] qhi[$];
    logic       m_half_v;
    logic [3:0] m_half;
    logic       m_ovf;

    logic [7:0] obs_lo[$];
    logic [7:0] obs_hi[$];

    always #5 clk = ~clk;

    nibble_packer #(.FIFO_DEPTH(DEPTH), .LOW_FIRST(1'b1)) u_lo (
        .clk(clk), .clr(clr), .d(d), .d_en(d_en), .flush(flush),
        .out_data(lo_data), .out_valid(lo_valid), .out_ready(out_ready),
        .full(lo_full), .level(lo_level), .overflow(lo_ovf)
    );

    nibble_packer #(.FIFO_DEPTH(DEPTH), .LOW_FIRST(1'b0)) u_hi (
        .clk(clk), .clr(clr), .d(d), .d_en(d_en), .flush(flush),
        .out_data(hi_data), .out_valid(hi_valid), .out_ready(out_ready),
        .full(hi_full), .level(hi_level), .overflow(hi_ovf)
    );

    task automatic model_step(input logic c, input logic [3:0] dd,
                              input logic de, input logic fl,
                              input logic rd);
        logic       push;
        logic [7:0] blo, bhi;
        push = 1'b0;
        blo  = 8'h00;
        bhi  = 8'h00;
        if (c) begin
            qlo.delete();
            qhi.delete();
            m_half_v = 1'b0;
            m_half   = 4'h0;
            m_ovf    = 1'b0;
            return;
        end
        if (!m_half_v) begin
            if (de && fl) begin
                push = 1'b1;
                blo  = {4'h0, dd};
                bhi  = {dd, 4'h0};
            end else if (de) begin
                m_half   = dd;
                m_half_v = 1'b1;
            end
        end else begin
            if (de) begin
                push     = 1'b1;
                blo      = {dd, m_half};
                bhi      = {m_half, dd};
                m_half_v = 1'b0;
            end else if (fl) begin
                push     = 1'b1;
                blo      = {4'h0, m_half};
                bhi      = {m_half, 4'h0};
                m_half_v = 1'b0;
            end
        end
        if (qlo.size() != 0 && rd) begin
            void'(qlo.pop_front());
            void'(qhi.pop_front());
        end
        if (push) begin
            if (qlo.size() < DEPTH) begin
                qlo.push_back(blo);
                qhi.push_back(bhi);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic [27:0] exp_vec();
        int n;
        n = qlo.size();
        return {n != 0, n == DEPTH, 3'(n), m_ovf,
                (n != 0) ? qlo[0] : 8'h00,
                n != 0, n == DEPTH, 3'(n), m_ovf,
                (n != 0) ? qhi[0] : 8'h00};
    endfunction

    function automatic logic [27:0] obs_vec();
        return {lo_valid, lo_full, lo_level, lo_ovf, lo_data,
                hi_valid, hi_full, hi_level, hi_ovf, hi_data};
    endfunction

    task automatic cyc(input logic c, input logic [3:0] dd,
                       input logic de, input logic fl, input logic rd);
        clr       = c;
        d         = dd;
        d_en      = de;
        flush     = fl;
        out_ready = rd;
        if (!c && rd && lo_valid) obs_lo.push_back(lo_data);
        if (!c && rd && hi_valid) obs_hi.push_back(hi_data);
        @(posedge clk);
        model_step(c, dd, de, fl, rd);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", obs_vec(), 28'h0);
        end
    endtask

    task automatic test_ordered();
        logic [3:0] nib [8] = '{4'h0, 4'h1, 4'h2, 4'h3,
                                4'h4, 4'h5, 4'hE, 4'hF};
        logic [7:0] exb [4] = '{8'h10, 8'h32, 8'h54, 8'hFE};
        logic [31:0] got;
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
        obs_lo.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, nib[i], 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ordered_model i=%0d got %h exp %h",
                         i, obs_vec(), exp_vec());
            end
            if (i % 2 == 1) begin
                checks++;
                if ({lo_valid, lo_data} !== {1'b1, exb[i/2]}) begin
                    errors++;
                    $display("FAIL ordered_byte i=%0d got %b/%h exp 1/%h",
                             i, lo_valid, lo_data, exb[i/2]);
                end
            end
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        got = {obs_lo[0], obs_lo[1], obs_lo[2], obs_lo[3]};
        checks++;
        if (obs_lo.size() != 4 || got !== 32'h103254FE) begin
            errors++;
            $display("FAIL ordered_stream got n=%0d %h exp n=4 103254fe",
                     obs_lo.size(), got);
        end
        checks++;
        if ({lo_level, lo_ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL ordered_end got lvl=%0d ovf=%b exp 0/0",
                     lo_level, lo_ovf);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        int          elv;
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
            elv = (i / 2 > 4) ? 4 : i / 2;
            checks++;
            if (lo_level !== 3'(elv) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_fill i=%0d got lvl=%0d exp %0d",
                         i, lo_level, elv);
            end
        end
        checks++;
        if ({lo_full, lo_ovf, hi_ovf} !== 3'b111) begin
            errors++;
            $display("FAIL bp_full_ovf got %b%b%b exp 111",
                     lo_full, lo_ovf, hi_ovf);
        end
        obs_lo.delete();
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        got = {obs_lo[0], obs_lo[1], obs_lo[2], obs_lo[3]};
        checks++;
        if (obs_lo.size() != 4 || got !== 32'h21436587) begin
            errors++;
            $display("FAIL bp_drain got n=%0d %h exp n=4 21436587",
                     obs_lo.size(), got);
        end
        checks++;
        if ({lo_valid, lo_level} !== 4'b0000) begin
            errors++;
            $display("FAIL bp_empty got v=%b lvl=%0d exp 0/0",
                     lo_valid, lo_level);
        end
    endtask

    task automatic test_full_pushpop();
        logic [39:0] got;
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) cyc(1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'hB, 1'b1, 1'b0, 1'b0);
        obs_lo.delete();
        cyc(1'b0, 4'hC, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({lo_level, lo_full, lo_ovf} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fpp_level got lvl=%0d f=%b ovf=%b exp 4/1/0",
                     lo_level, lo_full, lo_ovf);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        got = {obs_lo[0], obs_lo[1], obs_lo[2], obs_lo[3], obs_lo[4]};
        checks++;
        if (obs_lo.size() != 5 || got !== 40'h21436587CB) begin
            errors++;
            $display("FAIL fpp_order got n=%0d %h exp n=5 21436587cb",
                     obs_lo.size(), got);
        end
    endtask

    task automatic test_flush();
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({lo_level, lo_data, hi_data} !== {3'd1, 8'h07, 8'h70}) begin
            errors++;
            $display("FAIL flush_half got lvl=%0d lo=%h hi=%h exp 1/07/70",
                     lo_level, lo_data, hi_data);
        end
        obs_lo.delete();
        obs_hi.delete();
        cyc(1'b0, 4'h9, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({lo_level, lo_data, hi_data} !== {3'd1, 8'h09, 8'h90}) begin
            errors++;
            $display("FAIL flush_den got lvl=%0d lo=%h hi=%h exp 1/09/90",
                     lo_level, lo_data, hi_data);
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({lo_valid, lo_level, hi_level} !== 7'b0) begin
            errors++;
            $display("FAIL flush_empty got v=%b lvl=%0d exp 0/0",
                     lo_valid, lo_level);
        end
        checks++;
        if (obs_lo.size() != 2 || {obs_lo[0], obs_lo[1], obs_hi[0], obs_hi[1]}
            !== 32'h07097090) begin
            errors++;
            $display("FAIL flush_pops got n=%0d %h%h exp n=2 0709",
                     obs_lo.size(), obs_lo[0], obs_lo[1]);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) cyc(1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'h6, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({lo_valid, lo_level, lo_ovf, hi_valid} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_clear got v=%b lvl=%0d ovf=%b exp 0/0/0",
                     lo_valid, lo_level, lo_ovf);
        end
        cyc(1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h4, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({lo_level, lo_data, hi_data} !== {3'd1, 8'h43, 8'h34}) begin
            errors++;
            $display("FAIL rstmid_half got lvl=%0d lo=%h hi=%h exp 1/43/34",
                     lo_level, lo_data, hi_data);
        end
    endtask

    task automatic test_stall();
        logic rdy [3] = '{1'b0, 1'b0, 1'b1};
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) cyc(1'b0, 4'(i), 1'b1, 1'b0, 1'b0);
        obs_lo.delete();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b0, rdy[i]);
            checks++;
            if (rdy[i] == 1'b0 &&
                {lo_level, lo_data} !== {3'd3, 8'h21}) begin
                errors++;
                $display("FAIL stall_hold i=%0d got lvl=%0d d=%h exp 3/21",
                         i, lo_level, lo_data);
            end else if (rdy[i] == 1'b1 &&
                {lo_level, lo_data} !== {3'd2, 8'h43}) begin
                errors++;
                $display("FAIL stall_pop got lvl=%0d d=%h exp 2/43",
                         lo_level, lo_data);
            end
        end
        checks++;
        if (obs_lo.size() != 1 || obs_lo[0] !== 8'h21) begin
            errors++;
            $display("FAIL stall_count got n=%0d exp 1", obs_lo.size());
        end
    endtask

    task automatic test_random();
        logic c, de, fl, rd;
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            c  = ($urandom_range(0, 59) == 0);
            de = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 9) < 2);
            rd = ($urandom_range(0, 9) < (i < 300 ? 3 : 7));
            cyc(c, 4'($urandom), de, fl, rd);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random i=%0d got %h exp %h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        clr       = 1'b1;
        d         = 4'h0;
        d_en      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_half_v  = 1'b0;
        m_half    = 4'h0;
        m_ovf     = 1'b0;
        test_reset();
        test_ordered();
        test_backpressure();
        test_full_pushpop();
        test_flush();
        test_reset_mid();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream consumer of the 4-bit register stage (hardreg).
- Takes the registered 4-bit stream `q` plus a qualifier and pairs consecutive nibbles into bytes.
- Buffers completed bytes in a small first-word-fall-through FIFO with a valid/ready output handshake.
- Provides a flush for an odd trailing nibble, and a sticky overflow flag for bytes lost when the FIFO is full.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
- LOW_FIRST, 1, 1: first nibble of a pair lands in bits [3:0]; 0: first nibble lands in bits [7:4].

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous reset, active-high.
- d  input  4  nibble from the upstream register output.
- d_en  input  1  `d` valid this cycle; sampled at the rising edge of `clk`.
- flush  input  1  emit a pending half byte as a zero-padded byte.
- out_data  output  8  FIFO head byte; valid only while `out_valid` is high.
- out_valid  output  1  FIFO is non-empty.
- out_ready  input  1  downstream accepts `out_data` this cycle.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- level  output  $clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
- overflow  output  1  sticky; set when a completed byte is dropped.

Behaviour:
- Reset (`clr` high at an edge): outputs 0 next cycle.
  - Clears `out_data`, `out_valid`, `full`, `level`, `overflow`, the half register and the pack state.
  - Reset mid-operation discards all FIFO contents and any pending nibble.
  - `clr` overrides every other input.
- Pack FSM, two states: EMPTY, HALF.
  - EMPTY, `d_en`=1, `flush`=0: store `d` in the half register; go to HALF; no push.
  - EMPTY, `d_en`=1, `flush`=1: push the padded byte immediately; stay in EMPTY.
    - LOW_FIRST=1: byte = {4'h0, d}.
    - LOW_FIRST=0: byte = {d, 4'h0}.
  - EMPTY, `flush` alone: no effect.
  - HALF, `d_en`=1: push the completed byte; go to EMPTY; `flush` ignored.
    - LOW_FIRST=1: byte = {d, half}.
    - LOW_FIRST=0: byte = {half, d}.
  - HALF, `flush`=1, `d_en`=0: push the padded half byte; go to EMPTY.
    - LOW_FIRST=1: byte = {4'h0, half}.
    - LOW_FIRST=0: byte = {half, 4'h0}.
  - HALF, both low: hold.
  - At most one push per cycle.
- FIFO:
  - pop = `out_valid` & `out_ready`.
  - push is accepted if `full`=0, or if pop occurs in the same cycle (full with simultaneous pop: `level` stays FIFO_DEPTH and the order is preserved).
  - push while `full` with no pop: byte dropped, `overflow` set to 1 at that edge; FIFO unchanged; pack FSM still advances to EMPTY.
  - `overflow` clears only on `clr`.
  - push and pop together when not full: `level` unchanged.
  - pop when empty is impossible; `out_ready` is don't-care while `out_valid`=0.
- Read/write pointers wrap modulo FIFO_DEPTH.
- Output timing:
  - First-word fall-through: `out_data` = head entry combinationally from storage.
  - `out_valid` = (`level` != 0).
  - `full` = (`level` == FIFO_DEPTH).
- Latency: the byte completed at edge N is visible on `out_data`/`out_valid` in cycle N+1 when the FIFO was empty.
- `out_data` holds stable while `out_valid`=1 and `out_ready`=0.

Test Plan:
- Reset then ordered stream, LOW_FIRST=1, `out_ready`=1:
  - Stimulus: `d_en` pulses with nibbles 0,1,2,3,4,5,E,F.
  - Required: bytes 0x10, 0x32, 0x54, 0xFE in order, each one cycle after its pair completes.
  - Required at end: `level`=0, `overflow`=0.
- Backpressure fill, FIFO_DEPTH=4, `out_ready`=0:
  - Stimulus: 10 nibbles 1..A.
  - Required: `level` 1→4, `full`=1 after the 4th byte (0xA9 dropped), `overflow`=1.
  - Then `out_ready`=1: pops 0x21, 0x43, 0x65, 0x87; `out_valid` drops after the last pop.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full and `out_ready`=1 on the cycle a pair completes.
  - Required: `level` stays 4, new byte enqueued last, `overflow` unchanged (0).
- Flush cases, LOW_FIRST=1:
  - Nibble 7 then `flush` → byte 0x07.
  - `flush` with `d_en` in EMPTY and `d`=9 → byte 0x09.
  - `flush` in EMPTY alone → no push.
  - LOW_FIRST=0, nibble 7 + `flush` → 0x70.
- Reset mid-operation:
  - Stimulus: 2 bytes queued plus a pending half, `clr` pulsed one cycle.
  - Required: next cycle `out_valid`=0, `level`=0, `overflow`=0.
  - Required: next nibbles 3,4 produce 0x43, proving the half was discarded.
- Hold under stall:
  - Stimulus: `out_ready` toggling 0,0,1 across three cycles.
  - Required: `out_data` constant during the stall cycles; exactly one pop on the `out_ready`=1 cycle.
